// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage: ID/EX register with load-use stall detection and EX/MEM, MEM/WB operand forwarding.
module id_ex_operand_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      id_valid,
  input  logic [3:0]                id_alu_operation,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs_addr,
  input  logic [REG_ADDR_WIDTH-1:0] id_rt_addr,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd_addr,
  input  logic [DATA_WIDTH-1:0]     id_rs_data,
  input  logic [DATA_WIDTH-1:0]     id_rt_data,
  input  logic [DATA_WIDTH-1:0]     id_imm,
  input  logic [4:0]                id_shamt,
  input  logic                      id_alu_src,
  input  logic                      id_reg_write,
  input  logic                      id_mem_read,
  input  logic                      flush,
  input  logic                      exmem_reg_write,
  input  logic [REG_ADDR_WIDTH-1:0] exmem_rd,
  input  logic [DATA_WIDTH-1:0]     exmem_result,
  input  logic                      memwb_reg_write,
  input  logic [REG_ADDR_WIDTH-1:0] memwb_rd,
  input  logic [DATA_WIDTH-1:0]     memwb_result,
  output logic                      stall_id,
  output logic                      ex_valid,
  output logic [3:0]                alu_operation,
  output logic [DATA_WIDTH-1:0]     alu_rs,
  output logic [DATA_WIDTH-1:0]     alu_a,
  output logic [DATA_WIDTH-1:0]     alu_b,
  output logic [4:0]                alu_shamt,
  output logic [REG_ADDR_WIDTH-1:0] ex_rd,
  output logic                      ex_reg_write,
  output logic                      ex_mem_read
);
  localparam logic [3:0] OP_SLL = 4'd6, OP_SRL = 4'd7, OP_BRANCH = 4'd8;
  logic                      valid_q, alu_src_q, reg_write_q, mem_read_q;
  logic [3:0]                op_q;
  logic [REG_ADDR_WIDTH-1:0] rs_addr_q, rt_addr_q, rd_q;
  logic [DATA_WIDTH-1:0]     rs_data_q, rt_data_q, imm_q;
  logic [4:0]                shamt_q;
  logic                      id_rt_used, rt_on_a;
  logic [DATA_WIDTH-1:0]     fwd_rs, fwd_rt;
  // Shifts and branches read rt even when alu_src selects the immediate for B.
  assign id_rt_used = !id_alu_src || id_alu_operation == OP_SLL || id_alu_operation == OP_SRL ||
                      id_alu_operation == OP_BRANCH;
  assign stall_id = id_valid && ex_mem_read && rd_q != '0 &&
                    (rd_q == id_rs_addr || (rd_q == id_rt_addr && id_rt_used));
  always_ff @(posedge clk) begin
    if (reset || flush || stall_id) begin
      valid_q     <= 1'b0;
      op_q        <= '0;
      rs_addr_q   <= '0;
      rt_addr_q   <= '0;
      rd_q        <= '0;
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      imm_q       <= '0;
      shamt_q     <= '0;
      alu_src_q   <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
    end else begin
      valid_q     <= id_valid;
      op_q        <= id_alu_operation;
      rs_addr_q   <= id_rs_addr;
      rt_addr_q   <= id_rt_addr;
      rd_q        <= id_rd_addr;
      rs_data_q   <= id_rs_data;
      rt_data_q   <= id_rt_data;
      imm_q       <= id_imm;
      shamt_q     <= id_shamt;
      alu_src_q   <= id_alu_src;
      reg_write_q <= id_reg_write;
      mem_read_q  <= id_mem_read;
    end
  end
  // EX/MEM is younger than MEM/WB, so it wins; r0 is hardwired and never forwarded.
  assign fwd_rs = (rs_addr_q != '0 && exmem_reg_write && exmem_rd == rs_addr_q) ? exmem_result :
                  (rs_addr_q != '0 && memwb_reg_write && memwb_rd == rs_addr_q) ? memwb_result : rs_data_q;
  assign fwd_rt = (rt_addr_q != '0 && exmem_reg_write && exmem_rd == rt_addr_q) ? exmem_result :
                  (rt_addr_q != '0 && memwb_reg_write && memwb_rd == rt_addr_q) ? memwb_result : rt_data_q;
  assign rt_on_a       = op_q == OP_SLL || op_q == OP_SRL || op_q == OP_BRANCH;
  assign alu_rs        = fwd_rs;
  assign alu_a         = rt_on_a ? fwd_rt : fwd_rs;
  assign alu_b         = alu_src_q ? imm_q : fwd_rt;
  assign alu_shamt     = shamt_q;
  assign alu_operation = op_q;
  assign ex_valid      = valid_q;
  assign ex_rd         = rd_q;
  assign ex_reg_write  = valid_q && reg_write_q;
  assign ex_mem_read   = valid_q && mem_read_q;
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb_id_ex_operand_stage: directed and random checks of id_ex_operand_stage against a behavioural model.
module tb_id_ex_operand_stage;
  logic        clk = 1'b0;
  logic        reset, id_valid, id_alu_src, id_reg_write, id_mem_read, flush;
  logic [3:0]  id_alu_operation;
  logic [4:0]  id_rs_addr, id_rt_addr, id_rd_addr, id_shamt;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic        exmem_reg_write, memwb_reg_write;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_result;
  logic        stall_id, ex_valid, ex_reg_write, ex_mem_read;
  logic [3:0]  alu_operation;
  logic [31:0] alu_rs, alu_a, alu_b;
  logic [4:0]  alu_shamt, ex_rd;
  int checks = 0, errors = 0;

  typedef struct {
    logic valid, src, rw, mr;
    logic [3:0] op;
    logic [4:0] rs, rt, rd, sh;
    logic [31:0] rsd, rtd, imm;
  } ex_t;
  ex_t m;

  id_ex_operand_stage dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_alu_operation(id_alu_operation),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_rd_addr(id_rd_addr),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm), .id_shamt(id_shamt),
    .id_alu_src(id_alu_src), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .stall_id(stall_id), .ex_valid(ex_valid), .alu_operation(alu_operation), .alu_rs(alu_rs),
    .alu_a(alu_a), .alu_b(alu_b), .alu_shamt(alu_shamt), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] fwd(logic [4:0] a, logic [31:0] d);
    if (a != 0 && exmem_reg_write && exmem_rd == a) return exmem_result;
    if (a != 0 && memwb_reg_write && memwb_rd == a) return memwb_result;
    return d;
  endfunction

  function automatic logic exp_stall();
    logic uses_rt;
    if (!(id_valid && m.valid && m.mr && m.rd != 0)) return 1'b0;
    uses_rt = !id_alu_src || id_alu_operation inside {4'd6, 4'd7, 4'd8};
    return m.rd == id_rs_addr || (uses_rt && m.rd == id_rt_addr);
  endfunction

  task automatic set_id(logic v, logic [3:0] op, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                        logic [31:0] rsd, logic [31:0] rtd, logic [31:0] imm, logic [4:0] sh,
                        logic src, logic rw, logic mr);
    id_valid = v; id_alu_operation = op; id_rs_addr = rs; id_rt_addr = rt; id_rd_addr = rd;
    id_rs_data = rsd; id_rt_data = rtd; id_imm = imm; id_shamt = sh;
    id_alu_src = src; id_reg_write = rw; id_mem_read = mr;
  endtask

  task automatic set_fwd(logic ew, logic [4:0] erd, logic [31:0] eres,
                         logic mw, logic [4:0] mrd, logic [31:0] mres);
    exmem_reg_write = ew; exmem_rd = erd; exmem_result = eres;
    memwb_reg_write = mw; memwb_rd = mrd; memwb_result = mres;
  endtask

  // Compare every output against the model, then let one edge pass and advance the model.
  task automatic step();
    logic st;
    #1;
    st = exp_stall();
    chk("stall_id", {31'b0, stall_id}, {31'b0, st});
    chk("ex_valid", {31'b0, ex_valid}, {31'b0, m.valid});
    chk("alu_operation", {28'b0, alu_operation}, {28'b0, m.op});
    chk("alu_rs", alu_rs, fwd(m.rs, m.rsd));
    chk("alu_a", alu_a, m.op inside {4'd6, 4'd7, 4'd8} ? fwd(m.rt, m.rtd) : fwd(m.rs, m.rsd));
    chk("alu_b", alu_b, m.src ? m.imm : fwd(m.rt, m.rtd));
    chk("alu_shamt", {27'b0, alu_shamt}, {27'b0, m.sh});
    chk("ex_rd", {27'b0, ex_rd}, {27'b0, m.rd});
    chk("ex_reg_write", {31'b0, ex_reg_write}, {31'b0, m.valid && m.rw});
    chk("ex_mem_read", {31'b0, ex_mem_read}, {31'b0, m.valid && m.mr});
    @(posedge clk);
    if (reset || flush || st) m = '{default: '0};
    else begin
      m.valid = id_valid; m.op = id_alu_operation; m.rs = id_rs_addr; m.rt = id_rt_addr;
      m.rd = id_rd_addr; m.rsd = id_rs_data; m.rtd = id_rt_data; m.imm = id_imm;
      m.sh = id_shamt; m.src = id_alu_src; m.rw = id_reg_write; m.mr = id_mem_read;
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_fwd(0, 0, 0, 0, 0, 0);
    m = '{default: '0};
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    step();
    chk("reset_valid", {31'b0, ex_valid}, 32'd0);
    chk("reset_op", {28'b0, alu_operation}, 32'd0);
    // ADD r3 = r1 + r2
    set_id(1, 0, 1, 2, 3, 5, 7, 0, 0, 0, 1, 0);
    step();
    chk("add_a", alu_a, 32'd5);
    chk("add_b", alu_b, 32'd7);
    chk("add_rs", alu_rs, 32'd5);
    chk("add_rd", {27'b0, ex_rd}, 32'd3);
    chk("add_rw", {31'b0, ex_reg_write}, 32'd1);
    set_fwd(1, 1, 32'h10, 1, 1, 32'h20);
    #1 chk("fwd_exmem_wins", alu_a, 32'h10);
    set_fwd(1, 0, 32'h10, 1, 0, 32'h20);
    #1 chk("fwd_none", alu_a, 32'd5);
    set_id(1, 0, 0, 0, 3, 32'h33, 0, 0, 0, 0, 1, 0);
    step();
    chk("r0_not_fwd", alu_a, 32'h33);
    // Load-use: LW r4 then ADD r5 = r1 + r4
    set_fwd(0, 0, 0, 0, 0, 0);
    set_id(1, 0, 2, 0, 4, 0, 0, 8, 0, 1, 1, 1);
    step();
    set_id(1, 0, 1, 4, 5, 1, 2, 0, 0, 0, 1, 0);
    #1 chk("loaduse_stall", {31'b0, stall_id}, 32'd1);
    step();
    chk("loaduse_bubble", {31'b0, ex_valid}, 32'd0);
    #1 chk("loaduse_release", {31'b0, stall_id}, 32'd0);
    step();
    set_fwd(0, 0, 0, 1, 4, 32'hABCD);
    #1 chk("loaduse_fwd_b", alu_b, 32'hABCD);
    step();
    // SLL r5 = r6 << 3, then BRANCH r9, r9
    set_fwd(0, 0, 0, 0, 0, 0);
    set_id(1, 6, 0, 6, 5, 0, 1, 0, 3, 0, 1, 0);
    step();
    chk("sll_a", alu_a, 32'd1);
    chk("sll_shamt", {27'b0, alu_shamt}, 32'd3);
    set_id(1, 8, 9, 9, 0, 9, 9, 0, 0, 0, 0, 0);
    step();
    chk("br_rs", alu_rs, 32'd9);
    chk("br_a", alu_a, 32'd9);
    // flush squashes the incoming ADD
    set_id(1, 0, 1, 2, 3, 5, 7, 0, 0, 0, 1, 0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_valid", {31'b0, ex_valid}, 32'd0);
    chk("flush_rw", {31'b0, ex_reg_write}, 32'd0);
    // reset while a load-use stall is pending
    set_id(1, 0, 2, 0, 4, 0, 0, 8, 0, 1, 1, 1);
    step();
    set_id(1, 0, 4, 1, 5, 1, 2, 0, 0, 0, 1, 0);
    reset = 1'b1;
    #1 chk("rst_stall_pending", {31'b0, stall_id}, 32'd1);
    step();
    reset = 1'b0;
    chk("rst_mid_valid", {31'b0, ex_valid}, 32'd0);
    chk("rst_mid_rd", {27'b0, ex_rd}, 32'd0);
    chk("rst_mid_mr", {31'b0, ex_mem_read}, 32'd0);
    // Random traffic on a small register set to provoke hazards and forwarding collisions
    for (int i = 0; i < 400; i++) begin
      set_id($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), $urandom, $urandom, $urandom,
             5'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 2) == 0);
      set_fwd(1'($urandom), 5'($urandom_range(0, 3)), $urandom,
              1'($urandom), 5'($urandom_range(0, 3)), $urandom);
      flush = $urandom_range(0, 7) == 0;
      reset = $urandom_range(0, 39) == 0;
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
